// File: rtl/tracker_pkg.sv
// Shared types for the fetch/retire tracker: queue entry layout, FSM states, stats width.
package tracker_pkg;

    localparam int STAT_WIDTH  = 32;
    localparam int TRK_PC_W    = 16;
    localparam int TRK_INSTR_W = 16;

    typedef struct packed {
        logic [TRK_PC_W-1:0]    pc;
        logic [TRK_INSTR_W-1:0] instr;
    } trk_entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } trk_state_t;

endpackage

// File: rtl/tracker_fifo_mem.sv
// Entry storage for the tracker: one write port, one asynchronous read port, array not reset.
module tracker_fifo_mem
    import tracker_pkg::*;
#(
    parameter int  DEPTH   = 8,
    parameter type entry_t = trk_entry_t
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  entry_t                   wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output entry_t                   rdata
);

    entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_retire_tracker.sv
// In-order fetch/retire tracker with flush, overflow/underflow halt and err_clr recovery.
// Optional retire/flush statistics counters are built when TRACKER_STATS_EN is defined.
module fetch_retire_tracker
    import tracker_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         fetch_valid,
    input  logic [ADDR_WIDTH-1:0]        fetch_pc,
    input  logic [DATA_WIDTH-1:0]        fetch_instr,
    input  logic                         retire_valid,
    input  logic                         flush,
    input  logic                         err_clr,
    output logic                         retire_out_vld,
    output logic [ADDR_WIDTH-1:0]        retire_pc,
    output logic [DATA_WIDTH-1:0]        retire_instr,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         full,
    output logic                         empty,
    output logic                         err_overflow,
    output logic                         err_underflow,
    output logic [STAT_WIDTH-1:0]        retire_count,
    output logic [STAT_WIDTH-1:0]        flush_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    trk_state_t       state;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    entry_t           wr_entry, rd_entry;
    logic             run, do_retire, do_push, underflow, overflow;

    assign full     = (occupancy == OCC_MAX);
    assign empty    = (occupancy == '0);
    assign wr_entry = '{pc: fetch_pc, instr: fetch_instr};

    // err_clr overrides everything else, so it also masks the datapath enables.
    always_comb begin
        run       = (state == RUN) && !err_clr;
        do_retire = run && retire_valid && !empty;
        underflow = run && retire_valid && empty;
        do_push   = run && fetch_valid && !flush && !underflow && (!full || do_retire);
        overflow  = run && fetch_valid && !flush && !underflow && full && !do_retire;
    end

    tracker_fifo_mem #(.DEPTH(DEPTH), .entry_t(entry_t)) u_mem (
        .clk   (clk),
        .we    (do_push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= RUN;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            occupancy      <= '0;
            retire_out_vld <= 1'b0;
            retire_pc      <= '0;
            retire_instr   <= '0;
            err_overflow   <= 1'b0;
            err_underflow  <= 1'b0;
        end else if (err_clr) begin
            state          <= RUN;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            occupancy      <= '0;
            retire_out_vld <= 1'b0;
            err_overflow   <= 1'b0;
            err_underflow  <= 1'b0;
        end else begin
            retire_out_vld <= do_retire;
            if (do_retire) begin
                retire_pc    <= rd_entry.pc;
                retire_instr <= rd_entry.instr;
            end
            if (underflow) err_underflow <= 1'b1;
            if (overflow)  err_overflow  <= 1'b1;
            if (underflow || overflow) state <= HALT;
            // Flush drops the queue after the head has been captured for retire.
            if (run && flush) begin
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                occupancy <= '0;
            end else begin
                if (do_retire) rd_ptr <= rd_ptr + 1'b1;
                if (do_push)   wr_ptr <= wr_ptr + 1'b1;
                occupancy <= occupancy + OCC_W'(do_push) - OCC_W'(do_retire);
            end
        end
    end

`ifdef TRACKER_STATS_EN
    // Statistics survive err_clr; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_count <= '0;
            flush_count  <= '0;
        end else begin
            if (do_retire)   retire_count <= retire_count + 1'b1;
            if (run && flush) flush_count <= flush_count + 1'b1;
        end
    end
`else
    assign retire_count = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_fetch_retire_tracker.sv
// Directed bench for fetch_retire_tracker; stats checks adapt to TRACKER_STATS_EN.
module tb_fetch_retire_tracker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_valid, retire_valid, flush, err_clr;
    logic [15:0] fetch_pc, fetch_instr;
    logic        retire_out_vld, full, empty, err_overflow, err_underflow;
    logic [15:0] retire_pc, retire_instr;
    logic [3:0]  occupancy;
    logic [31:0] retire_count, flush_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    fetch_retire_tracker #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_valid    (fetch_valid),
        .fetch_pc       (fetch_pc),
        .fetch_instr    (fetch_instr),
        .retire_valid   (retire_valid),
        .flush          (flush),
        .err_clr        (err_clr),
        .retire_out_vld (retire_out_vld),
        .retire_pc      (retire_pc),
        .retire_instr   (retire_instr),
        .occupancy      (occupancy),
        .full           (full),
        .empty          (empty),
        .err_overflow   (err_overflow),
        .err_underflow  (err_underflow),
        .retire_count   (retire_count),
        .flush_count    (flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fetch_valid = 0; retire_valid = 0; flush = 0; err_clr = 0;
    endtask

    task automatic push(input logic [15:0] pc);
        fetch_valid = 1; fetch_pc = pc; fetch_instr = pc ^ 16'hA5A5;
        tick();
        fetch_valid = 0;
    endtask

    task automatic pop_expect(input string tag, input logic [15:0] pc);
        retire_valid = 1;
        tick();
        retire_valid = 0;
        chk({tag, "_vld"}, 32'(retire_out_vld), 32'd1);
        chk({tag, "_pc"}, 32'(retire_pc), 32'(pc));
    endtask

    initial begin
        idle();
        fetch_pc = '0; fetch_instr = '0;
        rst_n = 0;
        repeat (2) tick();
        chk("rst_vld", 32'(retire_out_vld), 0);
        chk("rst_pc", 32'(retire_pc), 0);
        chk("rst_occ", 32'(occupancy), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_errs", {30'd0, err_overflow, err_underflow}, 0);
        chk("rst_rcnt", retire_count, 0);
        chk("rst_fcnt", flush_count, 0);
        rst_n = 1;
        tick();

        // 1) basic order and one-cycle latency
        push(16'h0); push(16'h1); push(16'h2);
        chk("t1_occ", 32'(occupancy), 3);
        pop_expect("t1_r0", 16'h0);
        chk("t1_instr0", 32'(retire_instr), 32'h0000A5A5);
        pop_expect("t1_r1", 16'h1);
        pop_expect("t1_r2", 16'h2);
        tick();
        chk("t1_vld_drop", 32'(retire_out_vld), 0);
        chk("t1_pc_hold", 32'(retire_pc), 2);
        chk("t1_empty", 32'(empty), 1);

        // 2) fill, then fetch+retire while full
        for (int i = 0; i < 8; i++) push(16'h10 + 16'(i));
        chk("t2_full", 32'(full), 1);
        chk("t2_occ8", 32'(occupancy), 8);
        fetch_valid = 1; fetch_pc = 16'h18; fetch_instr = 16'h18 ^ 16'hA5A5;
        pop_expect("t2_fr", 16'h10);
        fetch_valid = 0;
        chk("t2_occ_hold", 32'(occupancy), 8);
        chk("t2_no_ovf", 32'(err_overflow), 0);
        for (int i = 1; i < 9; i++) pop_expect("t2_drain", 16'h10 + 16'(i));
        chk("t2_instr_last", 32'(retire_instr), 32'(16'h18 ^ 16'hA5A5));
        chk("t2_empty", 32'(empty), 1);

        // 3) retire+flush+fetch in one cycle
        for (int i = 0; i < 4; i++) push(16'h20 + 16'(i));
        flush = 1; fetch_valid = 1; fetch_pc = 16'h99; fetch_instr = 16'h1234;
        pop_expect("t3_head", 16'h20);
        idle();
        chk("t3_occ0", 32'(occupancy), 0);
        chk("t3_empty", 32'(empty), 1);
        push(16'h30);
        pop_expect("t3_after", 16'h30);

        // 4) overflow halts; err_clr recovers
        for (int i = 0; i < 8; i++) push(16'h40 + 16'(i));
        push(16'h48);
        chk("t4_ovf", 32'(err_overflow), 1);
        chk("t4_occ", 32'(occupancy), 8);
        retire_valid = 1;
        tick();
        retire_valid = 0;
        chk("t4_halt_vld", 32'(retire_out_vld), 0);
        chk("t4_halt_occ", 32'(occupancy), 8);
        err_clr = 1;
        tick();
        err_clr = 0;
        chk("t4_clr_ovf", 32'(err_overflow), 0);
        chk("t4_clr_empty", 32'(empty), 1);
        push(16'h50);
        pop_expect("t4_run", 16'h50);

        // 5) underflow with same-cycle fetch, then async reset mid-run
        retire_valid = 1; fetch_valid = 1; fetch_pc = 16'h60; fetch_instr = 16'h0;
        tick();
        idle();
        chk("t5_unf", 32'(err_underflow), 1);
        chk("t5_occ", 32'(occupancy), 0);
        chk("t5_vld", 32'(retire_out_vld), 0);
        err_clr = 1;
        tick();
        err_clr = 0;
        chk("t5_clr_unf", 32'(err_underflow), 0);
        push(16'h70); push(16'h71);
        pop_expect("t5_pre_rst", 16'h70);
        rst_n = 0;
        #1;
        chk("t5_rst_vld", 32'(retire_out_vld), 0);
        chk("t5_rst_pc", 32'(retire_pc), 0);
        chk("t5_rst_occ", 32'(occupancy), 0);
        chk("t5_rst_empty", 32'(empty), 1);
        tick();
        rst_n = 1;
        tick();

        // 6) statistics: 5 retires, 2 flushes, unaffected by err_clr
        for (int i = 0; i < 5; i++) push(16'h80 + 16'(i));
        for (int i = 0; i < 5; i++) pop_expect("t6_pop", 16'h80 + 16'(i));
        flush = 1;
        tick(); tick();
        flush = 0;
        err_clr = 1;
        tick();
        err_clr = 0;
`ifdef TRACKER_STATS_EN
        chk("t6_rcnt", retire_count, 5);
        chk("t6_fcnt", flush_count, 2);
`else
        chk("t6_rcnt_off", retire_count, 0);
        chk("t6_fcnt_off", flush_count, 0);
`endif
        chk("t6_empty", 32'(empty), 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
